// File: rtl/prog_mem_banked.sv
// Banked multi-port program memory: word-interleaved single-port SRAM banks, host-priority
// plus per-bank round-robin arbitration. Optional stall counters via PROG_MEM_STALL_CNT_EN.
module prog_mem_banked #(
  parameter int unsigned NumPorts  = 4,
  parameter int unsigned NumBanks  = 2,
  parameter int unsigned NumBytes  = 32768,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumPorts-1:0]             cl_req_i,
  input  logic [NumPorts*AddrWidth-1:0]   cl_addr_i,
  output logic [NumPorts-1:0]             cl_gnt_o,
  output logic [NumPorts-1:0]             cl_rvalid_o,
  output logic [NumPorts*DataWidth-1:0]   cl_rdata_o,
  input  logic                            host_req_i,
  input  logic                            host_we_i,
  input  logic [AddrWidth-1:0]            host_addr_i,
  input  logic [DataWidth-1:0]            host_wdata_i,
  input  logic [DataWidth/8-1:0]          host_be_i,
  output logic                            host_gnt_o,
  output logic                            host_rvalid_o,
  output logic [DataWidth-1:0]            host_rdata_o,
  output logic [NumPorts*CntWidth-1:0]    stall_cnt_o
);

  localparam int unsigned NumBe    = DataWidth / 8;
  localparam int unsigned BO       = $clog2(NumBe);
  localparam int unsigned LogBanks = $clog2(NumBanks);
  localparam int unsigned BankW    = (NumBanks > 1) ? LogBanks : 1;
  localparam int unsigned Rows     = NumBytes / NumBe / NumBanks;
  localparam int unsigned RowW     = (Rows > 1) ? $clog2(Rows) : 1;
  localparam int unsigned PtrW     = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  typedef logic [BankW-1:0] bank_t;
  typedef logic [RowW-1:0]  row_t;

  function automatic bank_t bank_of(input logic [AddrWidth-1:0] a);
    if (NumBanks == 1) return '0;
    return bank_t'(a >> BO);
  endfunction

  // Address bits above the row field are ignored, so the array aliases.
  function automatic row_t row_of(input logic [AddrWidth-1:0] a);
    if (Rows == 1) return '0;
    return row_t'(a >> (BO + LogBanks));
  endfunction

  logic [NumPorts-1:0] cl_gnt;
  logic                host_gnt;
  logic [NumBanks-1:0] bank_en;
  logic [NumBanks-1:0] bank_we;
  row_t                bank_row [NumBanks];
  logic [PtrW-1:0]     ptr_q [NumBanks];
  logic [PtrW-1:0]     ptr_d [NumBanks];
  bank_t               cl_bank [NumPorts];
  bank_t               host_bank;
  int                  idx;

  logic [NumPorts-1:0] cl_rvalid_q;
  bank_t               cl_bank_q [NumPorts];
  logic                host_rvalid_q;
  logic                host_wr_q;
  bank_t               host_bank_q;

  logic [DataWidth-1:0] mem_q [NumBanks][Rows];
  logic [DataWidth-1:0] bank_rdata_q [NumBanks];

  // Per bank: host first, then round-robin search from the bank pointer.
  always_comb begin
    cl_gnt    = '0;
    host_gnt  = 1'b0;
    bank_en   = '0;
    bank_we   = '0;
    idx       = 0;
    host_bank = bank_of(host_addr_i);
    for (int b = 0; b < NumBanks; b++) begin
      bank_row[b] = '0;
      ptr_d[b]    = ptr_q[b];
    end
    for (int p = 0; p < NumPorts; p++) begin
      cl_bank[p] = bank_of(cl_addr_i[p*AddrWidth +: AddrWidth]);
    end
    if (!rst_i) begin
      for (int b = 0; b < NumBanks; b++) begin
        if (host_req_i && host_bank == bank_t'(b)) begin
          host_gnt    = 1'b1;
          bank_en[b]  = 1'b1;
          bank_we[b]  = host_we_i;
          bank_row[b] = row_of(host_addr_i);
        end else begin
          for (int k = 0; k < NumPorts; k++) begin
            idx = (int'(ptr_q[b]) + k) % int'(NumPorts);
            if (!bank_en[b] && cl_req_i[idx] && cl_bank[idx] == bank_t'(b)) begin
              bank_en[b]  = 1'b1;
              cl_gnt[idx] = 1'b1;
              bank_row[b] = row_of(cl_addr_i[idx*AddrWidth +: AddrWidth]);
              ptr_d[b]    = PtrW'((idx + 1) % int'(NumPorts));
            end
          end
        end
      end
    end
  end

  // SRAM arrays are deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NumBanks; b++) begin
      if (bank_en[b]) begin
        if (bank_we[b]) begin
          for (int i = 0; i < NumBe; i++) begin
            if (host_be_i[i]) mem_q[b][bank_row[b]][i*8 +: 8] <= host_wdata_i[i*8 +: 8];
          end
        end else begin
          bank_rdata_q[b] <= mem_q[b][bank_row[b]];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cl_rvalid_q   <= '0;
      host_rvalid_q <= 1'b0;
      host_wr_q     <= 1'b0;
      host_bank_q   <= '0;
      for (int b = 0; b < NumBanks; b++) ptr_q[b] <= '0;
      for (int p = 0; p < NumPorts; p++) cl_bank_q[p] <= '0;
    end else begin
      cl_rvalid_q   <= cl_gnt;
      host_rvalid_q <= host_gnt;
      host_wr_q     <= host_gnt && host_we_i;
      host_bank_q   <= host_bank;
      for (int b = 0; b < NumBanks; b++) ptr_q[b] <= ptr_d[b];
      for (int p = 0; p < NumPorts; p++) cl_bank_q[p] <= cl_bank[p];
    end
  end

  always_comb begin
    cl_rdata_o = '0;
    for (int p = 0; p < NumPorts; p++) begin
      if (cl_rvalid_q[p]) cl_rdata_o[p*DataWidth +: DataWidth] = bank_rdata_q[cl_bank_q[p]];
    end
    host_rdata_o = '0;
    if (host_rvalid_q && !host_wr_q) host_rdata_o = bank_rdata_q[host_bank_q];
  end

  assign cl_gnt_o      = cl_gnt;
  assign cl_rvalid_o   = cl_rvalid_q;
  assign host_gnt_o    = host_gnt;
  assign host_rvalid_o = host_rvalid_q;

`ifdef PROG_MEM_STALL_CNT_EN
  logic [CntWidth-1:0] stall_q [NumPorts];
  logic [CntWidth-1:0] stall_d [NumPorts];

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      stall_d[p] = stall_q[p];
      if (cl_req_i[p] && !cl_gnt[p] && stall_q[p] != '1) stall_d[p] = stall_q[p] + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int p = 0; p < NumPorts; p++) stall_q[p] <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) stall_q[p] <= stall_d[p];
    end
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) stall_cnt_o[p*CntWidth +: CntWidth] = stall_q[p];
  end
`else
  assign stall_cnt_o = '0;
`endif

  // Requesters must hold req until granted.
  for (genvar p = 0; p < NumPorts; p++) begin : g_req_hold
    a_req_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      cl_req_i[p] && !cl_gnt_o[p] |=> cl_req_i[p]);
  end
  a_host_hold: assert property (@(posedge clk_i) disable iff (rst_i)
    host_req_i && !host_gnt_o |=> host_req_i);

endmodule
